// File: rtl/sram_loader.sv
// sram_loader: packs a byte stream into 16-bit words and writes them to an async SRAM.
// Define LOADER_VERIFY_EN to read each word back after writing and flag mismatches in err[1].
module sram_loader #(
    parameter int unsigned WE_CYCLES = 2,
    parameter logic [17:0] MAX_ADDR  = 18'h3FFFF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        SRAM_WE,
    output logic        SRAM_CE,
    output logic        SRAM_OE,
    output logic        SRAM_LB,
    output logic        SRAM_UB,
    output logic [17:0] SRAM_A,
    output logic [15:0] SRAM_DQ_OUT,
    output logic        SRAM_DQ_OE,
    input  logic [15:0] SRAM_D,
    output logic        done,
    output logic [1:0]  err,
    output logic [18:0] words_written
);
    typedef enum logic [2:0] {
        IDLE, SETUP, PULSE, HOLD,
`ifdef LOADER_VERIFY_EN
        VRD1, VRD2,
`endif
        DONE
    } loaderState;

    loaderState state, nextState;
    logic [17:0] addr;
    logic [15:0] word;
    logic        haveLow;
    logic [3:0]  pulseCnt;
    logic        errOvf, errVfy;
    logic        accept, pulseDone, endWord, commit;
    loaderState  finishState;

    assign accept      = in_valid && in_ready;
    assign pulseDone   = pulseCnt == 4'(WE_CYCLES - 1);
    assign endWord     = word[15:12] == 4'b0000;
    assign finishState = (endWord || addr == MAX_ADDR) ? DONE : IDLE;
`ifdef LOADER_VERIFY_EN
    assign commit = state == VRD2;
`else
    assign commit = state == HOLD;
    logic unusedSramD;
    assign unusedSramD = ^SRAM_D;
    assign errVfy      = 1'b0;
`endif

    assign in_ready      = state == IDLE && !RST;
    assign done          = state == DONE;
    assign err           = {errVfy, errOvf};
    assign SRAM_A        = addr;
    assign SRAM_DQ_OUT   = word;
    assign SRAM_LB       = 1'b0;
    assign SRAM_UB       = 1'b0;

    always_ff @(posedge CLK or posedge RST)
        if (RST) state <= IDLE;
        else     state <= nextState;

    always_comb begin
        nextState  = state;
        SRAM_WE    = 1'b1;
        SRAM_CE    = 1'b1;
        SRAM_OE    = 1'b1;
        SRAM_DQ_OE = 1'b0;
        case (state)
            IDLE:  if (accept && haveLow) nextState = SETUP;
            SETUP: begin
                SRAM_CE    = 1'b0;
                SRAM_DQ_OE = 1'b1;
                nextState  = PULSE;
            end
            PULSE: begin
                SRAM_CE    = 1'b0;
                SRAM_WE    = 1'b0;
                SRAM_DQ_OE = 1'b1;
                if (pulseDone) nextState = HOLD;
            end
            HOLD: begin
                SRAM_CE    = 1'b0;
                SRAM_DQ_OE = 1'b1;
`ifdef LOADER_VERIFY_EN
                nextState  = VRD1;
`else
                nextState  = finishState;
`endif
            end
`ifdef LOADER_VERIFY_EN
            VRD1: begin
                SRAM_CE   = 1'b0;
                SRAM_OE   = 1'b0;
                nextState = VRD2;
            end
            VRD2: begin
                SRAM_CE   = 1'b0;
                SRAM_OE   = 1'b0;
                nextState = finishState;
            end
`endif
            DONE:    nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr          <= '0;
            word          <= '0;
            haveLow       <= 1'b0;
            pulseCnt      <= '0;
            errOvf        <= 1'b0;
            words_written <= '0;
        end else begin
            if (accept) begin
                if (haveLow) word[15:8] <= in_data;
                else         word[7:0]  <= in_data;
                haveLow <= !haveLow;
            end
            pulseCnt <= state == PULSE ? pulseCnt + 4'd1 : 4'd0;
            // end-instruction takes priority over the address-overflow check
            if (commit) begin
                words_written <= words_written + 19'd1;
                if (!endWord && addr == MAX_ADDR) errOvf <= 1'b1;
                if (!endWord && addr != MAX_ADDR) addr <= addr + 18'd1;
            end
        end
    end

`ifdef LOADER_VERIFY_EN
    always_ff @(posedge CLK or posedge RST)
        if (RST)                                  errVfy <= 1'b0;
        else if (state == VRD2 && SRAM_D != word) errVfy <= 1'b1;
`endif
endmodule

// File: tb/tb_sram_loader.sv
// tb_sram_loader: scoreboard bench for sram_loader with a small SRAM model.
module tb_sram_loader;
    localparam int          WEC  = 2;
    localparam logic [17:0] MAXA = 18'd3;
`ifdef LOADER_VERIFY_EN
    localparam int VX = 2;
`else
    localparam int VX = 0;
`endif

    logic        CLK = 0, RST = 0, in_valid = 0;
    logic [7:0]  in_data = 0;
    logic        in_ready, SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB, SRAM_DQ_OE, done;
    logic [17:0] SRAM_A;
    logic [15:0] SRAM_DQ_OUT, SRAM_D;
    logic [1:0]  err;
    logic [18:0] words_written;

    sram_loader #(.WE_CYCLES(WEC), .MAX_ADDR(MAXA)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .SRAM_WE(SRAM_WE), .SRAM_CE(SRAM_CE), .SRAM_OE(SRAM_OE), .SRAM_LB(SRAM_LB), .SRAM_UB(SRAM_UB),
        .SRAM_A(SRAM_A), .SRAM_DQ_OUT(SRAM_DQ_OUT), .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_D(SRAM_D),
        .done(done), .err(err), .words_written(words_written)
    );

    always #10 CLK = ~CLK;

    logic [15:0] mem [0:7];
    logic        flip = 0;
    assign SRAM_D = (!SRAM_OE && !SRAM_CE)
                  ? (mem[SRAM_A[2:0]] ^ ((flip && SRAM_A == 18'd1) ? 16'h0008 : 16'h0000)) : 16'h0000;

    int nVec = 0, nBad = 0;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {logic [17:0] a; logic [15:0] d;} sbEntry;
    sbEntry      sb[$];
    logic [17:0] expAddr = 0;

    // SRAM model plus write scoreboard: a write completes when WE rises while the bus is still driven
    int   weLow = 0;
    logic prevWe = 1;
    always @(negedge CLK) begin
        if (!SRAM_WE) begin
            if (!SRAM_CE) mem[SRAM_A[2:0]] = SRAM_DQ_OUT;
            weLow++;
        end else if (!prevWe) begin
            if (SRAM_DQ_OE) begin
                sbEntry e;
                check("we_width", weLow, WEC);
                check("write_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_addr", SRAM_A, e.a);
                    check("wr_data", mem[SRAM_A[2:0]], e.d);
                end
            end
            weLow = 0;
        end
        prevWe = SRAM_WE;
    end

    task automatic sendByte(input logic [7:0] b, input int maxWait, output bit ok, output int waited);
        @(negedge CLK);
        in_valid = 1;
        in_data  = b;
        waited   = 0;
        while (!in_ready && waited < maxWait) begin
            @(negedge CLK);
            waited++;
        end
        ok = in_ready;
        if (ok) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic pushExp(input logic [15:0] w);
        sb.push_back('{expAddr, w});
        expAddr++;
    endtask

    task automatic sendWord(input logic [15:0] w, output int waited);
        bit ok;
        int wt;
        sendByte(w[7:0], 50, ok, waited);
        check("accept_lo", ok, 1);
        sendByte(w[15:8], 50, ok, wt);
        check("accept_hi", ok, 1);
        if (ok) pushExp(w);
    endtask

    task automatic doReset(input bit checkVals);
        @(negedge CLK);
        in_valid = 0;
        RST      = 1;
        sb.delete();
        expAddr  = 0;
        #2;
        if (checkVals) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_we", SRAM_WE, 1);
            check("rst_oe", SRAM_OE, 1);
            check("rst_ce", SRAM_CE, 1);
            check("rst_dq_oe", SRAM_DQ_OE, 0);
            check("rst_addr", SRAM_A, 0);
            check("rst_dq_out", SRAM_DQ_OUT, 0);
            check("rst_done", done, 0);
            check("rst_err", err, 0);
            check("rst_words", words_written, 0);
        end
        @(negedge CLK);
        RST = 0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (!done && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("done", done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          ok;
        int          wt;
        logic [15:0] stream [4] = '{16'h8123, 16'h9456, 16'hA789, 16'h0BCD};
        for (int i = 0; i < 8; i++) mem[i] = 16'hDEAD;

        // basic two-word load with latency and bus checks
        doReset(1);
        @(negedge CLK);
        check("idle_ready", in_ready, 1);
        sendByte(8'h0F, 50, ok, wt);
        sendByte(8'h80, 50, ok, wt);
        pushExp(16'h800F);
        @(negedge CLK);
        check("setup_we", SRAM_WE, 1);
        check("setup_dq_oe", SRAM_DQ_OE, 1);
        check("setup_ce", SRAM_CE, 0);
        check("setup_dq_out", SRAM_DQ_OUT, 16'h800F);
        check("busy_ready", in_ready, 0);
        @(negedge CLK);
        check("pulse_we", SRAM_WE, 0);
        sendWord(16'h0000, wt);
        waitDone();
        check("m0", mem[0], 16'h800F);
        check("m1", mem[1], 16'h0000);
        check("words2", words_written, 2);
        check("err2", err, 0);
        check("done_ready", in_ready, 0);
        check("done_ce", SRAM_CE, 1);
        check("done_dq_oe", SRAM_DQ_OE, 0);

        // back-to-back stream with in_valid held high
        doReset(0);
        for (int i = 0; i < 4; i++) begin
            sendWord(stream[i], wt);
            if (i > 0) check("stream_busy_cycles", wt, WEC + 2 + VX);
        end
        waitDone();
        check("stream_words", words_written, 4);
        check("stream_err", err, 0);
        check("stream_m3", mem[3], 16'h0BCD);
        check("stream_sb_empty", sb.size(), 0);

        // address overflow at MAX_ADDR
        doReset(0);
        for (int i = 0; i < 4; i++) sendWord(16'h8001, wt);
        waitDone();
        sendByte(8'h01, 20, ok, wt);
        check("ovf_not_accepted", ok, 0);
        in_valid = 0;
        check("ovf_err", err, 2'b01);
        check("ovf_words", words_written, 4);
        check("ovf_sb_empty", sb.size(), 0);

        // reset during the second pulse cycle
        doReset(0);
        sendByte(8'h11, 50, ok, wt);
        sendByte(8'h81, 50, ok, wt);
        @(posedge CLK);
        @(posedge CLK);
        #5;
        RST = 1;
        in_valid = 0;
        #1;
        check("abort_we", SRAM_WE, 1);
        check("abort_ce", SRAM_CE, 1);
        check("abort_addr", SRAM_A, 0);
        sb.delete();
        expAddr = 0;
        #2;
        RST = 0;
        sendWord(16'h0022, wt);
        waitDone();
        check("restart_m0", mem[0], 16'h0022);
        check("restart_words", words_written, 1);

        // odd byte discarded by reset
        doReset(0);
        sendByte(8'h55, 50, ok, wt);
        check("odd_accept", ok, 1);
        doReset(0);
        sendWord(16'h0001, wt);
        waitDone();
        check("odd_m0", mem[0], 16'h0001);

`ifdef LOADER_VERIFY_EN
        doReset(0);
        flip = 1;
        sendWord(16'h8001, wt);
        sendWord(16'h8002, wt);
        check("vfy_err_w0", err, 0);
        sendWord(16'h8003, wt);
        check("vfy_err_w1", err, 2'b10);
        sendWord(16'h0004, wt);
        waitDone();
        check("vfy_err_end", err, 2'b10);
        check("vfy_words", words_written, 4);
        check("vfy_m3", mem[3], 16'h0004);
        flip = 0;
`endif

        check("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end
endmodule

// File: doc/sram_loader.md
SRAM_LOADER -- requirements
Module: sram_loader

Interface
REQ-001 Parameter WE_CYCLES, default 2: number of cycles SRAM_WE is held low per write; legal range 1..15.
REQ-002 Parameter MAX_ADDR, default 18'h3FFFF: highest SRAM word address the loader writes.
REQ-003 CLK  input  1  system clock, 50 MHz; the block has one clock.
REQ-004 RST  input  1  reset; asynchronous, active-high.
REQ-005 in_valid  input  1  byte-stream valid.
REQ-006 in_data  input  8  byte-stream data.
REQ-007 in_ready  output  1  byte-stream ready.
REQ-008 SRAM_WE, SRAM_CE, SRAM_OE  output  1 each  active-low SRAM write enable, chip enable and output enable.
REQ-009 SRAM_LB, SRAM_UB  output  1 each  active-low byte lanes; both are held at 0.
REQ-010 SRAM_A  output  18  word address.
REQ-011 SRAM_DQ_OUT  output  16  write data.
REQ-012 SRAM_DQ_OE  output  1  the top level drives the data bus when this is 1.
REQ-013 SRAM_D  input  16  read data; used only by the verify option.
REQ-014 done  output  1  load finished; sticky.
REQ-015 err  output  2  bit0 = address overflow, bit1 = verify mismatch; each bit is sticky.
REQ-016 words_written  output  19  count of completed word writes.

Function
REQ-017 A byte transfers on a rising CLK edge when in_valid and in_ready are both 1.
REQ-018 Byte order: the first byte of each pair is word[7:0], the second is word[15:8].
REQ-019 in_ready = 1 only in state IDLE with done = 0.
REQ-020 States: IDLE, SETUP, PULSE, HOLD, VRD1, VRD2, DONE.
REQ-021 IDLE: hold a received low byte; on acceptance of the high byte, go to SETUP.
REQ-022 SETUP (1 cycle): SRAM_A = address, SRAM_DQ_OUT = word, SRAM_DQ_OE = 1, SRAM_CE = 0, SRAM_WE = 1.
REQ-023 PULSE (WE_CYCLES cycles): as SETUP, but SRAM_WE = 0.
REQ-024 HOLD (1 cycle): SRAM_WE = 1; address and data stay driven.
REQ-025 HOLD completes the write: words_written increments; the next state follows REQ-026 to REQ-028 in priority order.
REQ-026 If word[15:12] = 4'b0000 (end instruction), go to DONE.
REQ-027 Else if address = MAX_ADDR, set err[0] and go to DONE.
REQ-028 Else increment the address and go to IDLE.
REQ-029 Latency: high byte accepted at edge k -> SRAM_WE falls after edge k+1 -> in_ready returns after edge k+2+WE_CYCLES.
REQ-030 While busy, in_valid is ignored and no byte is lost or consumed.
REQ-031 DONE: done = 1, in_ready = 0, SRAM_CE = 1, SRAM_DQ_OE = 0; remain in DONE until reset.
REQ-032 SRAM_OE = 1 in every state except VRD1 and VRD2.
REQ-033 SRAM_DQ_OE = 0 in every state except SETUP, PULSE and HOLD.

Reset
REQ-034 Asserting RST immediately forces: state IDLE; address 0; low-byte holding register empty.
REQ-035 Asserting RST also forces: SRAM_WE = 1, SRAM_OE = 1, SRAM_CE = 1, SRAM_DQ_OE = 0.
REQ-036 Asserting RST also forces: SRAM_A = 0, SRAM_DQ_OUT = 0, done = 0, err = 0, words_written = 0, in_ready = 0.
REQ-037 Reset mid-PULSE terminates the write with no further WE activity; a pending odd byte is discarded.

Configuration
REQ-038 Macro LOADER_VERIFY_EN compiles in read-back verification.
REQ-039 With LOADER_VERIFY_EN: HOLD goes to VRD1; VRD1 and VRD2 drive SRAM_CE = 0, SRAM_OE = 0, SRAM_DQ_OE = 0 at the same address.
REQ-040 With LOADER_VERIFY_EN: at the end of VRD2, if SRAM_D != word, set err[1]; REQ-025 to REQ-028 then apply from VRD2 instead of HOLD; loading continues after a mismatch.
REQ-041 Without LOADER_VERIFY_EN: VRD1 and VRD2 do not exist, and err[1] is tied to 0.

Verification
REQ-042 Bytes 0x0F,0x80,0x00,0x00 -> mem[0] = 16'h800F, mem[1] = 16'h0000, done = 1, words_written = 2, err = 0.
REQ-043 in_valid held high with a new byte every cycle -> in_ready low from the high byte to HOLD exit; memory image equals the byte stream exactly.
REQ-044 MAX_ADDR = 3, five words 16'h8001 -> mem[0..3] written, err[0] = 1, done = 1, words_written = 4, fifth byte pair not accepted.
REQ-045 RST pulsed during the second PULSE cycle -> SRAM_WE = 1 within the same cycle; restarted stream writes from address 0.
REQ-046 Single byte 0x55, reset, then bytes 0x01,0x00 -> mem[0] = 16'h0001; then done = 1.
REQ-047 With LOADER_VERIFY_EN, SRAM model flips bit 3 at address 1 -> err[1] = 1 after word 1; remaining words are still written and done = 1.
